// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes, protection default and the
// byte-strobe merge used by write-mask and register-bank blocks.
package axi4_lite_pkg;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } axi4_resp_t;

    localparam logic [2:0] AXI_PROT_DEFAULT = 3'b000;

    function automatic logic [63:0] apply_wstrb(
        input logic [63:0] old_data,
        input logic [63:0] new_data,
        input logic [7:0]  strb
    );
        logic [63:0] merged;
        merged = old_data;
        for (int i = 0; i < 8; i++) begin
            if (strb[i]) begin
                merged[i*8 +: 8] = new_data[i*8 +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/axi4_lite_if.sv
// AXI4-Lite bundle. Every channel uses valid/ready: a transfer happens on the
// rising edge where both are high, and valid plus its payload hold until then.
interface axi4_lite_if #(
    parameter int ADDR_BIT_WIDTH = 4,
    parameter int DATA_BIT_WIDTH = 32
);
    logic                          awvalid;
    logic                          awready;
    logic [ADDR_BIT_WIDTH-1:0]     awaddr;
    logic [2:0]                    awprot;
    logic                          wvalid;
    logic                          wready;
    logic [DATA_BIT_WIDTH-1:0]     wdata;
    logic [DATA_BIT_WIDTH/8-1:0]   wstrb;
    logic                          bvalid;
    logic                          bready;
    logic [1:0]                    bresp;
    logic                          arvalid;
    logic                          arready;
    logic [ADDR_BIT_WIDTH-1:0]     araddr;
    logic [2:0]                    arprot;
    logic                          rvalid;
    logic                          rready;
    logic [DATA_BIT_WIDTH-1:0]     rdata;
    logic [1:0]                    rresp;

    modport mst_port (
        output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
               arvalid, araddr, arprot, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport slv_port (
        input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
               arvalid, araddr, arprot, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/axi4_lite_cmd_mst.sv
// Single-outstanding AXI4-Lite master: turns one command (read or write) into
// an AXI4-Lite transaction and returns a single response beat.
module axi4_lite_cmd_mst
    import axi4_lite_pkg::*;
#(
    parameter int ADDR_BIT_WIDTH = 4,
    parameter int DATA_BIT_WIDTH = 32
) (
    input  logic                        i_clk,
    input  logic                        i_arst_n,
    input  logic                        i_req_valid,
    output logic                        o_req_ready,
    input  logic                        i_req_wr,
    input  logic [ADDR_BIT_WIDTH-1:0]   i_req_addr,
    input  logic [DATA_BIT_WIDTH-1:0]   i_req_wdata,
    input  logic [DATA_BIT_WIDTH/8-1:0] i_req_wstrb,
    output logic                        o_rsp_valid,
    input  logic                        i_rsp_ready,
    output logic                        o_rsp_wr,
    output logic [DATA_BIT_WIDTH-1:0]   o_rsp_rdata,
    output logic [1:0]                  o_rsp_resp,
    output logic                        o_busy,
    output logic [2:0]                  o_dbg_state,
    axi4_lite_if.mst_port               if_m_axi4_lite
);

    if (ADDR_BIT_WIDTH != if_m_axi4_lite.ADDR_BIT_WIDTH ||
        DATA_BIT_WIDTH != if_m_axi4_lite.DATA_BIT_WIDTH) begin : g_param_mismatch
        $error("axi4_lite_cmd_mst: widths differ from the connected axi4_lite_if");
    end
    if (DATA_BIT_WIDTH != 32 && DATA_BIT_WIDTH != 64) begin : g_bad_data_width
        $error("axi4_lite_cmd_mst: DATA_BIT_WIDTH must be 32 or 64");
    end

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_AW_W = 3'd1,
        ST_WR_B    = 3'd2,
        ST_RD_AR   = 3'd3,
        ST_RD_R    = 3'd4,
        ST_RSP     = 3'd5
    } state_t;

    state_t                      state;
    logic                        req_ready_q;
    logic                        busy_q;
    logic                        awvalid_q;
    logic                        wvalid_q;
    logic                        bready_q;
    logic                        arvalid_q;
    logic                        rready_q;
    logic [ADDR_BIT_WIDTH-1:0]   addr_q;
    logic [DATA_BIT_WIDTH-1:0]   wdata_q;
    logic [DATA_BIT_WIDTH/8-1:0] wstrb_q;
    logic                        rsp_valid_q;
    logic                        rsp_wr_q;
    logic [DATA_BIT_WIDTH-1:0]   rsp_rdata_q;
    logic [1:0]                  rsp_resp_q;

    // A channel counts as done once its valid has dropped or it handshakes now.
    logic aw_done;
    logic w_done;
    assign aw_done = !awvalid_q || if_m_axi4_lite.awready;
    assign w_done  = !wvalid_q  || if_m_axi4_lite.wready;

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            state       <= ST_IDLE;
            req_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_wr_q    <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= RESP_OKAY;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_ready_q && i_req_valid) begin
                        req_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        addr_q      <= i_req_addr;
                        wdata_q     <= i_req_wdata;
                        wstrb_q     <= i_req_wstrb;
                        rsp_wr_q    <= i_req_wr;
                        if (i_req_wr) begin
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            state     <= ST_WR_AW_W;
                        end else begin
                            arvalid_q <= 1'b1;
                            state     <= ST_RD_AR;
                        end
                    end else begin
                        req_ready_q <= 1'b1;
                    end
                end
                ST_WR_AW_W: begin
                    if (awvalid_q && if_m_axi4_lite.awready) awvalid_q <= 1'b0;
                    if (wvalid_q && if_m_axi4_lite.wready)   wvalid_q  <= 1'b0;
                    if (aw_done && w_done) begin
                        bready_q <= 1'b1;
                        state    <= ST_WR_B;
                    end
                end
                ST_WR_B: begin
                    if (if_m_axi4_lite.bvalid) begin
                        bready_q    <= 1'b0;
                        rsp_resp_q  <= if_m_axi4_lite.bresp;
                        rsp_rdata_q <= '0;
                        rsp_valid_q <= 1'b1;
                        state       <= ST_RSP;
                    end
                end
                ST_RD_AR: begin
                    if (if_m_axi4_lite.arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state     <= ST_RD_R;
                    end
                end
                ST_RD_R: begin
                    if (if_m_axi4_lite.rvalid) begin
                        rready_q    <= 1'b0;
                        rsp_resp_q  <= if_m_axi4_lite.rresp;
                        rsp_rdata_q <= if_m_axi4_lite.rdata;
                        rsp_valid_q <= 1'b1;
                        state       <= ST_RSP;
                    end
                end
                ST_RSP: begin
                    // Ready rises with the return to IDLE, so the earliest
                    // new acceptance is the following edge.
                    if (i_rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        req_ready_q <= 1'b1;
                        state       <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_req_ready = req_ready_q;
    assign o_busy      = busy_q;
    assign o_rsp_valid = rsp_valid_q;
    assign o_rsp_wr    = rsp_wr_q;
    assign o_rsp_rdata = rsp_rdata_q;
    assign o_rsp_resp  = rsp_resp_q;
    assign o_dbg_state = state;

    assign if_m_axi4_lite.awvalid = awvalid_q;
    assign if_m_axi4_lite.awaddr  = addr_q;
    assign if_m_axi4_lite.awprot  = AXI_PROT_DEFAULT;
    assign if_m_axi4_lite.wvalid  = wvalid_q;
    assign if_m_axi4_lite.wdata   = wdata_q;
    assign if_m_axi4_lite.wstrb   = wstrb_q;
    assign if_m_axi4_lite.bready  = bready_q;
    assign if_m_axi4_lite.arvalid = arvalid_q;
    assign if_m_axi4_lite.araddr  = addr_q;
    assign if_m_axi4_lite.arprot  = AXI_PROT_DEFAULT;
    assign if_m_axi4_lite.rready  = rready_q;

endmodule
